// File: rtl/pbit_rng_pkg.sv
// Shared types and constants for the p-bit RNG stream checker.
package pbit_rng_pkg;

    // Checker synchronisation states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Feedback taps of the 8-bit LFSR: bits 7,5,4,3.
    localparam logic [7:0] LFSR8_TAP_MASK = 8'hB8;

    // Zero insertion: 0x02 -> 0x00 -> 0x04 splices the all-zero state into the cycle.
    localparam logic [7:0] ZI_PRED = 8'h02;
    localparam logic [7:0] ZI_SUCC = 8'h04;

    // Full sequence length including the inserted zero.
    localparam int unsigned RNG_PERIOD = 256;

endpackage

// File: rtl/pbit_rng_next.sv
// Combinational successor function of the RNG sequence, including zero insertion.
module pbit_rng_next
    import pbit_rng_pkg::*;
(
    input  logic [7:0] i_x,
    output logic [7:0] o_next
);

    // Successor: zero-insertion special cases first, otherwise shift in the tap parity.
    always_comb begin
        o_next = {i_x[6:0], ^(i_x & LFSR8_TAP_MASK)};
        if (i_x == ZI_PRED) begin
            o_next = 8'h00;
        end else if (i_x == 8'h00) begin
            o_next = ZI_SUCC;
        end
    end

endmodule

// File: rtl/pbit_rng_stream_checker.sv
// Self-synchronising checker for the p-bit RNG output stream.
// Hunts for the sequence, verifies LOCK_COUNT consecutive predictions, then flywheels
// and counts mispredictions. Optional macro PBIT_RNG_CHK_PERIOD_EN adds a sticky
// period_err flag checking that 0x00 samples recur every RNG_PERIOD valid samples.
module pbit_rng_stream_checker
    import pbit_rng_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
`ifdef PBIT_RNG_CHK_PERIOD_EN
    ,
    output logic             period_err
`endif
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [7:0]       r_pred;
    logic [7:0]       w_pred_nxt;
    logic [3:0]       r_run;
    logic [3:0]       w_run_nxt;
    logic [3:0]       r_miss;
    logic [3:0]       w_miss_nxt;
    logic             r_err_pulse;
    logic             w_err_nxt;
    logic             w_smp_inc;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_smp_cnt;
    logic [7:0]       w_next_data;
    logic [7:0]       w_next_pred;
    logic             w_match;
    logic [3:0]       w_run_inc;
    logic [3:0]       w_miss_inc;

    pbit_rng_next u_next_data (
        .i_x    (in_data),
        .o_next (w_next_data)
    );

    pbit_rng_next u_next_pred (
        .i_x    (r_pred),
        .o_next (w_next_pred)
    );

    assign w_match    = (in_data == r_pred);
    assign w_run_inc  = r_run + 4'd1;
    assign w_miss_inc = r_miss + 4'd1;

    // State, predictor and run-length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_pred      <= 8'h00;
            r_run       <= 4'd0;
            r_miss      <= 4'd0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pred      <= w_pred_nxt;
            r_run       <= w_run_nxt;
            r_miss      <= w_miss_nxt;
            r_err_pulse <= w_err_nxt;
        end
    end

    // Next-state logic: only valid samples advance the checker.
    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_run_nxt   = r_run;
        w_miss_nxt  = r_miss;
        w_err_nxt   = 1'b0;
        w_smp_inc   = 1'b0;
        if (in_valid) begin
            unique case (r_state)
                HUNT: begin
                    w_pred_nxt  = w_next_data;
                    w_run_nxt   = 4'd0;
                    w_state_nxt = VERIFY;
                end
                VERIFY: begin
                    if (w_match) begin
                        w_pred_nxt = w_next_pred;
                        w_run_nxt  = w_run_inc;
                        if (w_run_inc == LOCK_N) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = 4'd0;
                        end
                    end else begin
                        w_pred_nxt = w_next_data;
                        w_run_nxt  = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the predictor never follows the data once locked.
                    w_pred_nxt = w_next_pred;
                    w_smp_inc  = 1'b1;
                    if (w_match) begin
                        w_miss_nxt = 4'd0;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == LOSS_N) begin
                            w_state_nxt = HUNT;
                            w_run_nxt   = 4'd0;
                            w_miss_nxt  = 4'd0;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Saturating statistics counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt) begin
            r_err_cnt <= '0;
            r_smp_cnt <= '0;
        end else begin
            if (w_err_nxt && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_smp_inc && (r_smp_cnt != '1)) begin
                r_smp_cnt <= r_smp_cnt + 1'b1;
            end
        end
    end

    assign locked       = (r_state == LOCKED);
    assign err_pulse    = r_err_pulse;
    assign err_count    = r_err_cnt;
    assign sample_count = r_smp_cnt;

`ifdef PBIT_RNG_CHK_PERIOD_EN
    logic [8:0] r_per_cnt;
    logic       r_per_armed;
    logic       r_period_err;
    logic       w_zero_seen;
    logic       w_per_bad;

    assign w_zero_seen = (r_state == LOCKED) && in_valid && (in_data == 8'h00);
    // r_per_cnt holds the samples since the last zero, so correct spacing is PERIOD-1.
    assign w_per_bad   = w_zero_seen && r_per_armed && (r_per_cnt != 9'(RNG_PERIOD - 1));

    // Zero-to-zero spacing tracker; the first zero after locking only arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt    <= 9'd0;
            r_per_armed  <= 1'b0;
            r_period_err <= 1'b0;
        end else begin
            if (r_state != LOCKED) begin
                r_per_cnt   <= 9'd0;
                r_per_armed <= 1'b0;
            end else if (in_valid) begin
                if (in_data == 8'h00) begin
                    r_per_cnt   <= 9'd0;
                    r_per_armed <= 1'b1;
                end else if (r_per_cnt != '1) begin
                    r_per_cnt <= r_per_cnt + 9'd1;
                end
            end
            if (clear_cnt) begin
                r_period_err <= 1'b0;
            end else if (w_per_bad) begin
                r_period_err <= 1'b1;
            end
        end
    end

    assign period_err = r_period_err;
`endif

endmodule

// File: tb/tb_pbit_rng_stream_checker.sv
// Scoreboard bench for pbit_rng_stream_checker: the driver pushes expected outputs,
// the monitor pops and compares them on the falling edge once they are due.
module tb_pbit_rng_stream_checker;

    localparam int unsigned CW     = 8;
    localparam int unsigned LOCK_N = 4;
    localparam int unsigned LOSS_N = 3;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          clear_cnt = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] sample_count;
`ifdef PBIT_RNG_CHK_PERIOD_EN
    logic          period_err;
`endif

    pbit_rng_stream_checker #(
        .LOCK_COUNT (LOCK_N),
        .LOSS_COUNT (LOSS_N),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .clear_cnt    (clear_cnt),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .sample_count (sample_count)
`ifdef PBIT_RNG_CHK_PERIOD_EN
        ,
        .period_err   (period_err)
`endif
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint due;
        bit     hand;
        int     l, p, ec, sc, pe;
        int     hl, hp, hec, hsc, hpe;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Independent reference for the sequence successor.
    function automatic logic [7:0] next_ref(input logic [7:0] x);
        logic fb;
        fb = x[7] ^ x[5] ^ x[4] ^ x[3];
        if (x == 8'h02) return 8'h00;
        if (x == 8'h00) return 8'h04;
        return {x[6:0], fb};
    endfunction

    // Reference model state (0 hunt, 1 verify, 2 locked).
    int         m_st = 0, m_run = 0, m_miss = 0, m_ec = 0, m_sc = 0, m_ep = 0;
    int         m_pcnt = 0, m_armed = 0, m_perr = 0;
    logic [7:0] m_pred = 8'h00;

    task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit c);
        bit ec_inc, sc_inc, perr_set, mt;
        ec_inc = 0; sc_inc = 0; perr_set = 0;
        m_ep = 0;
        if (r) begin
            m_st = 0; m_pred = 8'h00; m_run = 0; m_miss = 0; m_ec = 0; m_sc = 0;
            m_pcnt = 0; m_armed = 0; m_perr = 0;
            return;
        end
        if (v) begin
            mt = (d == m_pred);
            case (m_st)
                0: begin
                    m_pred = next_ref(d); m_run = 0; m_st = 1;
                end
                1: begin
                    if (mt) begin
                        m_run++;
                        m_pred = next_ref(m_pred);
                        if (m_run == LOCK_N) begin
                            m_st = 2; m_miss = 0; m_pcnt = 0; m_armed = 0;
                        end
                    end else begin
                        m_pred = next_ref(d); m_run = 0;
                    end
                end
                default: begin
                    if (d == 8'h00) begin
                        if (m_armed != 0 && m_pcnt != 255) perr_set = 1;
                        m_armed = 1; m_pcnt = 0;
                    end else if (m_pcnt < 511) begin
                        m_pcnt++;
                    end
                    m_pred = next_ref(m_pred);
                    sc_inc = 1;
                    if (mt) begin
                        m_miss = 0;
                    end else begin
                        m_ep = 1; ec_inc = 1; m_miss++;
                        if (m_miss == LOSS_N) begin
                            m_st = 0; m_run = 0; m_miss = 0;
                        end
                    end
                end
            endcase
        end
        if (c) begin
            m_ec = 0; m_sc = 0; m_perr = 0;
        end else begin
            if (ec_inc && m_ec < CMAX) m_ec++;
            if (sc_inc && m_sc < CMAX) m_sc++;
            if (perr_set) m_perr = 1;
        end
    endtask

    // Drive one cycle and queue the expected post-edge outputs (hpe < 0: no hand check).
    task automatic issue(input bit r, input bit v, input logic [7:0] d, input bit c,
                         input bit h, input int hl, input int hp, input int hec,
                         input int hsc, input int hpe);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_data = d; clear_cnt = c;
        model_step(r, v, d, c);
        e.due = cyc + 1; e.hand = h;
        e.l = (m_st == 2) ? 1 : 0; e.p = m_ep; e.ec = m_ec; e.sc = m_sc; e.pe = m_perr;
        e.hl = hl; e.hp = hp; e.hec = hec; e.hsc = hsc; e.hpe = hpe;
        q.push_back(e);
    endtask

    task automatic drv(input bit r, input bit v, input logic [7:0] d, input bit c);
        issue(r, v, d, c, 1'b0, 0, 0, 0, 0, -1);
    endtask

    logic [7:0] g = 8'h01;

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            drv(1'b0, 1'b1, g, 1'b0);
            g = next_ref(g);
        end
    endtask

    // Monitor: compare every due expectation against the DUT.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check("locked", int'(locked), e.l);
            check("err_pulse", int'(err_pulse), e.p);
            check("err_count", int'(err_count), e.ec);
            check("sample_count", int'(sample_count), e.sc);
`ifdef PBIT_RNG_CHK_PERIOD_EN
            check("period_err", int'(period_err), e.pe);
`endif
            if (e.hand) begin
                check("hand_locked", int'(locked), e.hl);
                check("hand_err_pulse", int'(err_pulse), e.hp);
                check("hand_err_count", int'(err_count), e.hec);
                check("hand_sample_count", int'(sample_count), e.hsc);
`ifdef PBIT_RNG_CHK_PERIOD_EN
                if (e.hpe >= 0) check("hand_period_err", int'(period_err), e.hpe);
`endif
            end
        end
    end

    logic [7:0] lock_vec [5];

    initial begin
        lock_vec = '{8'h01, 8'h02, 8'h00, 8'h04, 8'h08};

        // Reset state.
        issue(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        issue(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);

        // Lock from reset: locked rises after the fifth sample.
        for (int i = 0; i < 5; i++) begin
            issue(0, 1, lock_vec[i], 0, 1, (i == 4) ? 1 : 0, 0, 0, 0, 0);
        end

        // Single error: FF replaces 11, then 23 and 47 continue the stream.
        issue(0, 1, 8'hFF, 0, 1, 1, 1, 1, 1, -1);
        issue(0, 1, 8'h23, 0, 1, 1, 0, 1, 2, -1);
        issue(0, 1, 8'h47, 0, 1, 1, 0, 1, 3, -1);

        // Bubbles: valid pattern 1,0,0,1.
        issue(0, 1, 8'h8E, 0, 1, 1, 0, 1, 4, -1);
        issue(0, 0, 8'h55, 0, 1, 1, 0, 1, 4, -1);
        issue(0, 0, 8'hAA, 0, 1, 1, 0, 1, 4, -1);
        issue(0, 1, 8'h1C, 0, 1, 1, 0, 1, 5, -1);
        g = 8'h38;

        // Clear counters while idle; lock is kept.
        issue(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0);

        // Loss of lock after three consecutive misses.
        issue(0, 1, 8'h00, 0, 1, 1, 1, 1, 1, -1);
        issue(0, 1, 8'h00, 0, 1, 1, 1, 2, 2, -1);
        issue(0, 1, 8'h00, 0, 1, 0, 1, 3, 3, -1);
        for (int i = 0; i < 3; i++) g = next_ref(g);

        // Relock with LOCK_COUNT+1 correct samples.
        feed(4);
        issue(0, 1, g, 0, 1, 1, 0, 3, 3, -1);
        g = next_ref(g);

        // Clear concurrent with an error: counts zero, pulse still fires.
        if (g == 8'h00) feed(1);
        issue(0, 1, 8'hFF, 1, 1, 1, 1, 0, 0, 0);
        g = next_ref(g);
        issue(0, 1, g, 0, 1, 1, 0, 0, 1, -1);
        g = next_ref(g);

        // Full periods with saturation.
        issue(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0);
        feed(1023);
        issue(0, 1, g, 0, 1, 1, 0, 0, CMAX, 0);
        g = next_ref(g);

        // Drop the 0x02 before a zero: the zero arrives one sample early.
        for (int i = 0; i < 300 && g != 8'h02; i++) feed(1);
        g = next_ref(g);
        issue(0, 1, g, 0, 1, 1, 1, 1, CMAX, 1);
        g = next_ref(g);

        // Reset mid-lock; the sample in the reset cycle is ignored.
        issue(1, 1, g, 0, 1, 0, 0, 0, 0, 0);
        g = 8'h01;
        feed(4);
        issue(0, 1, g, 0, 1, 1, 0, 0, 0, 0);

        drv(0, 0, 8'h00, 0);
        drv(0, 0, 8'h00, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
